handshake_monitor: RTL
======================

# handshake_monitor

- Synthesizable protocol monitor for a valid/ready stream.
- Checks each stalled beat for data stability, premature valid withdrawal and stall timeout, and measures stall length.
- Queues one event record per finding in a small show-ahead FIFO. The bench drains the FIFO and forwards records to the simulation event log (ASSERT_STBL/OBSERVE style); records are decoupled from the observed link by that FIFO.

## Interface
- DATA_W, 8, width of monitored data
- CNT_W, 16, width of stall/error counters
- DEPTH, 4, event FIFO entries (power of two, ≥2)
- TIMEOUT, 16, stall cycles before WARN event (2 ≤ TIMEOUT < 2^CNT_W)

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- mon_valid  in  1  observed valid
- mon_ready  in  1  observed ready
- mon_data  in  DATA_W  observed data
- evt_valid  out  1  head record available
- evt_ready  in  1  consumer pops head when evt_valid=1
- evt_level  out  3  severity: TRACE=0, DEBUG=1, INFO=2, WARN=3, ERROR=4, FATAL=5
- evt_code  out  2  0 XFER_OK, 1 STBL_LOSS, 2 VALID_DROP, 3 TIMEOUT
- evt_cycles  out  CNT_W  stall count attached to record
- evt_data  out  DATA_W  data attached to record
- overflow  out  1  sticky: event lost because FIFO was full
- err_cnt  out  CNT_W  ERROR events generated (including dropped), saturating

## Operation
- **States and entry:**
  - IDLE: no pending beat.
    - valid=1, ready=1: transfer with no stall; no event.
    - valid=1, ready=0: go to HOLD; latch mon_data as ref; stall_cnt=1; stable=1; to_fired=0.
  - HOLD: beat pending. Cases evaluated in priority order; at most one event per cycle:
    1. valid=0: push VALID_DROP (ERROR, cycles=stall_cnt, data=ref); go to IDLE.
    2. valid=1 and stable=1 and mon_data≠ref: push STBL_LOSS (ERROR, cycles=stall_cnt, data=mon_data); stable←0.
    3. valid=1, ready=0, no STBL_LOSS this cycle, stall_cnt+1==TIMEOUT, to_fired=0: push TIMEOUT (WARN, cycles=TIMEOUT, data=ref); to_fired←1.
- **Counting in HOLD:**
  - valid=1, ready=0: stall_cnt increments, saturating at 2^CNT_W−1.
  - A TIMEOUT suppressed by a same-cycle STBL_LOSS is not retried.
- **Leaving HOLD with valid=1, ready=1:**
  - Go to IDLE.
  - If stable=1 after step 2 (no change this cycle or earlier), push XFER_OK (INFO, cycles=stall_cnt, data=ref).
  - A change on the transfer cycle yields STBL_LOSS only.
- **Per-beat limits:**
  - ref is never updated inside HOLD.
  - Only one STBL_LOSS and one TIMEOUT per beat.
- **FIFO:**
  - Show-ahead; head fields are valid whenever evt_valid=1.
  - Push is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the record is dropped and overflow←1, held until reset.
- **err_cnt:** increments on every STBL_LOSS/VALID_DROP decision, pushed or dropped.
- **Reset:**
  - Asynchronous; a mid-beat reset discards the beat without an event.
  - Reset values: state IDLE, FIFO empty, evt_valid=0, evt_level/code/cycles/data=0, overflow=0, err_cnt=0.

## Timing
- **Event latency:** the event condition is sampled at edge N; the record is written at edge N. If the FIFO was empty, evt_valid=1 in the cycle after edge N.
- **Pop:** occurs at the edge where evt_valid=1 and evt_ready=1; the next record appears in the following cycle. evt_ready is ignored while evt_valid=0.
- **Back-to-back events:** one record per cycle, across beats. Example: VALID_DROP at edge N, then a new stall entry at edge N+1.
- **Record hold:** evt_valid and head fields stay constant until popped.
- **Full FIFO with simultaneous push and pop:** no loss, count unchanged.
- **Counter limits:** stall_cnt and err_cnt never wrap.

## Test plan
- valid=1, ready=0 for 3 cycles, data 0xA5 constant, then ready=1 → one record: XFER_OK, level 2, cycles 3, data 0xA5; err_cnt=0.
- Stall with data 0x11; data becomes 0x22 on the 2nd stall cycle; ready on the 4th → exactly one record: STBL_LOSS, level 4, cycles 1, data 0x22, no XFER_OK; err_cnt=1.
- Stall 2 cycles, then valid=0 → VALID_DROP, cycles 2, data = latched value; monitor returns to IDLE and the next beat with ready=1 produces no event.
- TIMEOUT=4: stall 6 cycles, then ready → TIMEOUT (level 3, cycles 4) followed by XFER_OK (cycles 6), in that order.
- evt_ready=0, DEPTH=4: generate 5 VALID_DROP beats → 4 records retained, overflow=1, err_cnt=5. Drain → records emerge in order, then evt_valid=0.
- rst_n pulsed low mid-stall, async relative to clk → all outputs 0 immediately; no event after release; FIFO empty.

Source files
------------

// File: rtl/handshake_monitor.sv
// Valid/ready stream monitor: checks stalled beats for stability, valid withdrawal and timeout,
// and queues one event record per finding in a show-ahead FIFO.
module handshake_monitor #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mon_valid_i,
   input  logic              mon_ready_i,
   input  logic [DATA_W-1:0] mon_data_i,
   output logic              evt_valid_o,
   input  logic              evt_ready_i,
   output logic [2:0]        evt_level_o,
   output logic [1:0]        evt_code_o,
   output logic [CNT_W-1:0]  evt_cycles_o,
   output logic [DATA_W-1:0] evt_data_o,
   output logic              overflow_o,
   output logic [CNT_W-1:0]  err_cnt_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   localparam logic [2:0] LvlInfo  = 3'd2;
   localparam logic [2:0] LvlWarn  = 3'd3;
   localparam logic [2:0] LvlError = 3'd4;

   localparam logic [1:0] CodeXferOk    = 2'd0;
   localparam logic [1:0] CodeStblLoss  = 2'd1;
   localparam logic [1:0] CodeValidDrop = 2'd2;
   localparam logic [1:0] CodeTimeout   = 2'd3;

   localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
   localparam logic [CNT_W:0]   TimeoutW  = (CNT_W+1)'(TIMEOUT);
   localparam logic [PtrW:0]    DepthW    = (PtrW+1)'(DEPTH);

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   typedef struct packed {
      logic [2:0]        level;
      logic [1:0]        code;
      logic [CNT_W-1:0]  cycles;
      logic [DATA_W-1:0] data;
   } rec_t;

   state_e            state_q;
   logic [DATA_W-1:0] ref_q;
   logic [CNT_W-1:0]  stall_q;
   logic              stable_q;
   logic              to_fired_q;

   logic              data_chg;
   logic              timeout_hit;
   logic [CNT_W:0]    stall_nxt;
   logic              push;
   logic              err_inc;
   rec_t              rec;

   rec_t              mem_q [DEPTH];
   logic [PtrW-1:0]   wr_q, rd_q;
   logic [PtrW:0]     cnt_q;
   logic              overflow_q;
   logic [CNT_W-1:0]  err_q;
   logic              pop, push_ok;

   // Event decision for the current cycle; at most one record per cycle.
   always_comb begin
      push        = 1'b0;
      err_inc     = 1'b0;
      rec         = '0;
      stall_nxt   = {1'b0, stall_q} + 1'b1;
      data_chg    = stable_q && (mon_data_i != ref_q);
      timeout_hit = (state_q == StHold) && mon_valid_i && !mon_ready_i && !data_chg &&
                    !to_fired_q && (stall_nxt == TimeoutW);
      if (state_q == StHold) begin
         if (!mon_valid_i) begin
            push    = 1'b1;
            err_inc = 1'b1;
            rec     = '{level: LvlError, code: CodeValidDrop, cycles: stall_q, data: ref_q};
         end else if (data_chg) begin
            push    = 1'b1;
            err_inc = 1'b1;
            rec     = '{level: LvlError, code: CodeStblLoss, cycles: stall_q, data: mon_data_i};
         end else if (mon_ready_i) begin
            if (stable_q) begin
               push = 1'b1;
               rec  = '{level: LvlInfo, code: CodeXferOk, cycles: stall_q, data: ref_q};
            end
         end else if (timeout_hit) begin
            push = 1'b1;
            rec  = '{level: LvlWarn, code: CodeTimeout, cycles: TimeoutW[CNT_W-1:0], data: ref_q};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         ref_q      <= '0;
         stall_q    <= '0;
         stable_q   <= 1'b0;
         to_fired_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (mon_valid_i && !mon_ready_i) begin
                  state_q    <= StHold;
                  ref_q      <= mon_data_i;
                  stall_q    <= CNT_W'(1);
                  stable_q   <= 1'b1;
                  to_fired_q <= 1'b0;
               end
            end
            StHold: begin
               if (!mon_valid_i) begin
                  state_q <= StIdle;
               end else begin
                  if (data_chg) stable_q <= 1'b0;
                  if (mon_ready_i) begin
                     state_q <= StIdle;
                  end else begin
                     if (stall_q != CntMax) stall_q <= stall_nxt[CNT_W-1:0];
                     if (timeout_hit) to_fired_q <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // A full FIFO still accepts a push when the head is popped on the same edge.
   assign pop     = (cnt_q != '0) && evt_ready_i;
   assign push_ok = push && ((cnt_q < DepthW) || pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= rec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         err_q      <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         if (push_ok && !pop) cnt_q <= cnt_q + 1'b1;
         else if (!push_ok && pop) cnt_q <= cnt_q - 1'b1;
         if (push && !push_ok) overflow_q <= 1'b1;
         if (err_inc && (err_q != CntMax)) err_q <= err_q + 1'b1;
      end
   end

   always_comb begin
      evt_valid_o  = (cnt_q != '0);
      evt_level_o  = '0;
      evt_code_o   = '0;
      evt_cycles_o = '0;
      evt_data_o   = '0;
      if (evt_valid_o) begin
         evt_level_o  = mem_q[rd_q].level;
         evt_code_o   = mem_q[rd_q].code;
         evt_cycles_o = mem_q[rd_q].cycles;
         evt_data_o   = mem_q[rd_q].data;
      end
      overflow_o = overflow_q;
      err_cnt_o  = err_q;
   end

endmodule
